// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// pc_pkg : shared operation encoding and request priority select for pc_unit
// Rev 1.0
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JUMP = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_t;

    // Reset is handled by the register itself; this resolves the remaining requests.
    function automatic pc_op_t pc_select_op(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jump
    );
        if (stall)     return PC_HOLD;
        else if (ret)  return PC_RET;
        else if (call) return PC_CALL;
        else if (jump) return PC_JUMP;
        else           return PC_INC;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_unit_ret_stack.sv
`default_nettype none
// ============================================================================
// ret_stack : LIFO of return addresses; push-when-full / pop-when-empty ignored
// Rev 1.0
// ============================================================================
module ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [AW-1:0]    w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && !full && !w_do_pop;
    // Clamp the top index to 0 when empty so the read never leaves the array.
    assign w_top_idx = empty ? '0 : AW'(count_q - CW'(1));
    assign dout      = mem_q[w_top_idx];
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (w_do_pop)
            count_d = count_q - CW'(1);
        else if (w_do_push)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            mem_q[count_q[AW-1:0]] <= din;
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// pc_unit : fetch-stage program counter with stall, jump, call and return
// Rev 1.0
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int                      WIDTH       = 8,
    parameter logic [WIDTH-1:0]        RESET_VEC   = '0,
    parameter int                      STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WIDTH-1:0]                   target,
    output logic [WIDTH-1:0]                   pc,
    output logic [WIDTH-1:0]                   pc_next,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               overflow_err,
    output logic                               underflow_err
);

    pc_op_t           w_op;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic [WIDTH-1:0] w_stk_dout;
    logic             w_stk_full;
    logic             w_stk_empty;

    assign w_op    = pc_select_op(stall, ret, call, jump);
    assign pc_next = pc_q + WIDTH'(1);

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        case (w_op)
            PC_INC:  pc_d = pc_next;
            PC_JUMP: pc_d = target;
            PC_CALL: begin
                pc_d = target;
                if (w_stk_full)
                    ovf_d = 1'b1;
            end
            PC_RET: begin
                // An empty-stack return behaves like a plain increment plus the flag.
                if (w_stk_empty) begin
                    unf_d = 1'b1;
                    pc_d  = pc_next;
                end else begin
                    pc_d  = w_stk_dout;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_op == PC_CALL),
        .pop   (w_op == PC_RET),
        .din   (pc_next),
        .dout  (w_stk_dout),
        .count (sp_count),
        .full  (w_stk_full),
        .empty (w_stk_empty)
    );

    assign pc            = pc_q;
    assign stack_full    = w_stk_full;
    assign stack_empty   = w_stk_empty;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_unit : directed vector table plus randomized run against a queue model
// Rev 1.0
// ============================================================================
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       jump = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic [2:0] sp_count;
    logic       stack_full;
    logic       stack_empty;
    logic       overflow_err;
    logic       underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH       (8),
        .RESET_VEC   (8'h00),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .pc            (pc),
        .pc_next       (pc_next),
        .sp_count      (sp_count),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    typedef struct {
        logic       rs, st, j, c, r;
        logic [7:0] t;
        logic [7:0] epc;
        int         esp;
        logic       eovf, eunf;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: return addresses kept in a plain queue.
    int         m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf;

    task automatic add(input logic rs, st, j, c, r, input logic [7:0] t,
                       input logic [7:0] epc, input int esp, input logic eovf, eunf);
        vec_t v;
        v.rs = rs; v.st = st; v.j = j; v.c = c; v.r = r; v.t = t;
        v.epc = epc; v.esp = esp; v.eovf = eovf; v.eunf = eunf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic rs, st, j, c, r, input logic [7:0] t);
        reset = rs; stall = st; jump = j; call = c; ret = r; target = t;
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [7:0] epc, input int esp,
                               input logic eovf, eunf);
        chk({tag, " pc"},       {24'd0, pc},            {24'd0, epc});
        chk({tag, " pc_next"},  {24'd0, pc_next},       32'((epc + 1) % 256));
        chk({tag, " sp_count"}, {29'd0, sp_count},      32'(esp));
        chk({tag, " full"},     {31'd0, stack_full},    {31'd0, (esp == DEPTH)});
        chk({tag, " empty"},    {31'd0, stack_empty},   {31'd0, (esp == 0)});
        chk({tag, " ovf"},      {31'd0, overflow_err},  {31'd0, eovf});
        chk({tag, " unf"},      {31'd0, underflow_err}, {31'd0, eunf});
    endtask

    task automatic model_step(input logic rs, st, j, c, r, input logic [7:0] t);
        if (rs) begin
            m_pc = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (st) begin
            // nothing changes
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
            else begin m_unf = 1'b1; m_pc = (m_pc + 1) % 256; end
        end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(8'((m_pc + 1) % 256));
            else m_ovf = 1'b1;
            m_pc = int'(t);
        end else if (j) begin
            m_pc = int'(t);
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    initial begin
        // rs st j c r target | pc sp ovf unf
        add(1,0,0,0,0,8'h00, 8'h00,0,0,0);
        for (int i = 1; i <= 5; i++) add(0,0,0,0,0,8'h00, 8'(i),0,0,0);
        add(0,0,1,0,0,8'hFE, 8'hFE,0,0,0);
        add(0,0,0,0,0,8'h00, 8'hFF,0,0,0);
        add(0,0,0,0,0,8'h00, 8'h00,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,0,8'h00, 8'h00,0,0,0);
        add(0,0,1,0,0,8'h10, 8'h10,0,0,0);
        add(0,0,0,1,0,8'h40, 8'h40,1,0,0);
        add(0,0,0,1,0,8'h80, 8'h80,2,0,0);
        add(0,0,0,0,1,8'h00, 8'h41,1,0,0);
        add(0,0,0,0,1,8'h00, 8'h11,0,0,0);
        add(1,0,0,0,0,8'h00, 8'h00,0,0,0);
        add(0,0,0,1,0,8'h20, 8'h20,1,0,0);
        add(0,0,0,1,0,8'h20, 8'h20,2,0,0);
        add(0,0,0,1,0,8'h20, 8'h20,3,0,0);
        add(0,0,0,1,0,8'h20, 8'h20,4,0,0);
        add(0,0,0,1,0,8'h20, 8'h20,4,1,0);
        add(0,0,0,0,1,8'h00, 8'h21,3,1,0);
        add(0,0,0,0,1,8'h00, 8'h21,2,1,0);
        add(0,0,0,0,1,8'h00, 8'h21,1,1,0);
        add(0,0,0,0,1,8'h00, 8'h01,0,1,0);
        add(1,0,0,0,0,8'h00, 8'h00,0,0,0);
        add(0,0,1,0,0,8'h30, 8'h30,0,0,0);
        add(0,0,0,0,1,8'h00, 8'h31,0,0,1);
        add(0,0,0,1,0,8'h60, 8'h60,1,0,1);
        add(0,0,0,1,1,8'h77, 8'h32,0,0,1);
        add(0,0,1,1,0,8'h55, 8'h55,1,0,1);
        add(0,0,0,1,0,8'h70, 8'h70,2,0,1);
        add(1,0,0,1,0,8'h90, 8'h00,0,0,0);
        add(0,0,0,0,0,8'h00, 8'h01,0,0,0);
        add(0,1,1,1,1,8'h99, 8'h01,0,0,0);

        foreach (vecs[i]) begin
            apply(vecs[i].rs, vecs[i].st, vecs[i].j, vecs[i].c, vecs[i].r, vecs[i].t);
            check_state($sformatf("vec%0d", i), vecs[i].epc, vecs[i].esp,
                        vecs[i].eovf, vecs[i].eunf);
        end

        // pc_next and stack status must not react to request inputs between edges.
        call = 1'b1; ret = 1'b1; target = 8'hC3;
        #1;
        chk("comb pc_next", {24'd0, pc_next}, 32'h02);
        chk("comb sp_count", {29'd0, sp_count}, 32'd0);
        chk("comb empty", {31'd0, stack_empty}, 32'd1);
        call = 1'b0; ret = 1'b0;

        // Randomized run against the model.
        model_step(1'b1, 0, 0, 0, 0, 8'h00);
        apply(1'b1, 0, 0, 0, 0, 8'h00);
        check_state("rand reset", 8'(m_pc), m_stk.size(), m_ovf, m_unf);
        for (int n = 0; n < 600; n++) begin
            logic       rs, st, j, c, r;
            logic [7:0] t;
            rs = ($urandom_range(99) < 2);
            st = ($urandom_range(99) < 10);
            r  = ($urandom_range(99) < 30);
            c  = ($urandom_range(99) < 35);
            j  = ($urandom_range(99) < 20);
            t  = 8'($urandom);
            model_step(rs, st, j, c, r, t);
            apply(rs, st, j, c, r, t);
            check_state($sformatf("rand%0d", n), 8'(m_pc), m_stk.size(), m_ovf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
